// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Brief    : Command FIFO plus IDLE/ISSUE/WAIT sequencer that drives an external
//            registered ALU and keeps the architectural accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       cmd_skipz,
    input  logic       cmd_last,
    output logic [2:0] alu_opcode,
    output logic [7:0] alu_accum,
    output logic [7:0] alu_data,
    input  logic [7:0] alu_out,
    output logic [7:0] acc,
    output logic       zero_flag,
    output logic       busy,
    output logic       done
);

    localparam int              c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0]   c_FULL_CNT = (c_AW + 1)'(DEPTH);
    localparam logic [1:0]      c_ST_IDLE  = 2'd0;
    localparam logic [1:0]      c_ST_ISSUE = 2'd1;
    localparam logic [1:0]      c_ST_WAIT  = 2'd2;

    // Entry layout: {op[12:10], data[9:2], skipz[1], last[0]}
    logic [12:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [7:0]      r_acc;
    logic [7:0]      r_alu_accum;
    logic [7:0]      r_alu_data;
    logic [2:0]      r_alu_opcode;
    logic            r_last;
    logic            r_done;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_skip;
    logic [12:0]     w_head;
    logic [2:0]      w_head_op;
    logic [7:0]      w_head_data;
    logic            w_head_skipz;
    logic            w_head_last;

    assign w_full       = (r_count == c_FULL_CNT);
    assign w_empty      = (r_count == '0);
    assign w_push       = cmd_valid && !w_full;
    assign w_pop        = (r_state == c_ST_IDLE) && !w_empty;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_op    = w_head[12:10];
    assign w_head_data  = w_head[9:2];
    assign w_head_skipz = w_head[1];
    assign w_head_last  = w_head[0];
    assign w_skip       = w_head_skipz && (r_acc == 8'h00);

    // Storage is not reset; pointer/count reset is what flushes the FIFO.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_op, cmd_data, cmd_skipz, cmd_last};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_pop && !w_skip) begin
                    w_state_next = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: w_state_next = c_ST_WAIT;
            c_ST_WAIT:  w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // ALU operands are held from the pop edge through ISSUE and WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc        <= 8'h00;
            r_alu_accum  <= 8'h00;
            r_alu_data   <= 8'h00;
            r_alu_opcode <= 3'b000;
            r_last       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        if (w_skip) begin
                            r_done <= w_head_last;
                        end else begin
                            r_alu_opcode <= w_head_op;
                            r_alu_data   <= w_head_data;
                            r_alu_accum  <= r_acc;
                            r_last       <= w_head_last;
                        end
                    end
                end
                c_ST_WAIT: begin
                    r_acc  <= alu_out;
                    r_done <= r_last;
                end
                default: begin
                end
            endcase
        end
    end

    assign cmd_ready  = !w_full;
    assign alu_opcode = r_alu_opcode;
    assign alu_accum  = r_alu_accum;
    assign alu_data   = r_alu_data;
    assign acc        = r_acc;
    assign zero_flag  = (r_acc == 8'h00);
    assign busy       = (r_state != c_ST_IDLE) || !w_empty;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning command FIFO depth; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: host command present.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: FIFO can accept a command.
REQ-006 The block SHALL have port cmd_op, input, 3 bits: ALU opcode for the command.
REQ-007 The block SHALL have port cmd_data, input, 8 bits: ALU data operand.
REQ-008 The block SHALL have port cmd_skipz, input, 1 bit: discard the command if acc==0 at issue.
REQ-009 The block SHALL have port cmd_last, input, 1 bit: last command of a program.
REQ-010 The block SHALL have port alu_opcode, output, 3 bits: opcode to the ALU.
REQ-011 The block SHALL have port alu_accum, output, 8 bits: accumulator operand to the ALU.
REQ-012 The block SHALL have port alu_data, output, 8 bits: data operand to the ALU.
REQ-013 The block SHALL have port alu_out, input, 8 bits: registered ALU result, valid one clk after opcode/operands are sampled.
REQ-014 The block SHALL have port acc, output, 8 bits: architectural accumulator.
REQ-015 The block SHALL have port zero_flag, output, 1 bit: high when acc==8'h00.
REQ-016 The block SHALL have port busy, output, 1 bit: high when FSM is not IDLE or FIFO is non-empty.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle pulse when a cmd_last command retires.

Function
REQ-018 The push rule SHALL be: a command is written into the FIFO on a clk edge where cmd_valid && cmd_ready; cmd_ready = !full; the FIFO keeps {op, data, skipz, last}.
REQ-019 The FIFO SHALL use wrap-around read/write pointers plus a count; push and pop in the same cycle leave the count unchanged; there is no empty-bypass (a push is visible to the FSM the following cycle).
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT.
REQ-021 IDLE, FIFO non-empty, head.skipz && acc==0: pop the head and stay IDLE; acc and alu_* outputs are unchanged; done pulses if head.last.
REQ-022 IDLE, FIFO non-empty, otherwise: pop the head, register alu_opcode<=head.op, alu_data<=head.data, alu_accum<=acc, latch last_r<=head.last, go to ISSUE.
REQ-023 ISSUE SHALL last exactly one cycle, during which the ALU samples its inputs, with alu_* held stable; next state is WAIT.
REQ-024 In WAIT, at the end of the cycle: acc<=alu_out, done<=last_r, next state IDLE.
REQ-025 Issue-to-writeback latency SHALL be: pop edge E, ALU capture edge E+1, acc update edge E+2; with an empty FIFO, cmd accepted at edge 0 gives acc updated at edge 3.
REQ-026 Throughput SHALL be one command per 3 cycles; the FIFO keeps accepting commands during ISSUE/WAIT until full.
REQ-027 zero_flag SHALL be combinational from acc and SHALL NOT use the ALU zero output, which reflects the old accumulator.
REQ-028 The block SHALL perform no arithmetic; all saturation and sign behaviour comes from the ALU; acc is 8 bits with no extension.
REQ-029 Opcode values SHALL be passed through unchecked; 3'b000 (pass accum) is a legal no-op.

Reset
REQ-030 On reset at any clk edge: FSM->IDLE; FIFO pointers and count->0 (contents flushed); acc, alu_accum, alu_data->8'h00; alu_opcode->3'b000; last_r, done->0.
REQ-031 Reset SHALL have priority over a simultaneous push, pop or writeback; an in-flight command is abandoned and no done is emitted; cmd_ready is high the cycle after reset deasserts.

Verification
REQ-032 Basic program: push {111,8'h07}, then {001,8'h05,last} -> acc=8'h0C after the second WAIT, done pulses exactly once, zero_flag=0.
REQ-033 Saturation pass-through: push {111,8'h70}, {001,8'h20,last} -> acc=8'h7F.
REQ-034 Full/backpressure: with DEPTH=4, push 6 commands back-to-back while the first is in ISSUE -> cmd_ready drops after the FIFO holds 4; no command is lost or duplicated; all 6 retire in order.
REQ-035 Skip-on-zero: acc=0, push {001,8'h09,skipz,last} -> no ISSUE state, acc stays 8'h00, done pulses one cycle after the pop.
REQ-036 Reset mid-operation: assert reset during WAIT of {111,8'h55,last} with 2 commands queued -> acc=8'h00, FIFO empty, busy=0, no done.
REQ-037 Timing: a single command accepted at edge 0 into an empty FIFO -> alu_opcode valid after edge 1, acc updated at edge 3.
